// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Delivers good words on a valid/ready port and pulses framing, parity and overrun errors.
module serial_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             sin,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  // state  | meaning
  // IDLE   | line idle, waiting for a 0 start bit
  // DATA   | shifting in WIDTH data bits, LSB first
  // PARITY | sampling the even-parity bit
  // STOP   | sampling the stop bit and resolving the frame
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             perr;
  logic             start, shift, latch_par, stop_edge;
  logic             last_bit, perr_eff, good, load, ovr;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign perr_eff = PARITY_EN && perr;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift     = 1'b0;
    latch_par = 1'b0;
    stop_edge = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            start     = 1'b1;
            state_nxt = DATA;
          end
        end
        DATA: begin
          shift = 1'b1;
          if (last_bit) state_nxt = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          latch_par = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          stop_edge = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A good word replaces the held one only if the consumer frees it on the same edge.
  assign good = stop_edge && sin && !perr_eff;
  assign load = good && (!out_valid || out_ready);
  assign ovr  = good && out_valid && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (start) begin
        cnt  <= '0;
        perr <= 1'b0;
      end
      if (shift) begin
        shreg <= {sin, shreg[WIDTH-1:1]};
        if (cnt != CW'(WIDTH)) cnt <= cnt + CW'(1);
      end
      if (latch_par) perr <= sin ^ (^shreg);

      frame_err  <= stop_edge && !sin;
      parity_err <= stop_edge && sin && perr_eff;
      overrun    <= ovr;

      if (load) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames; a monitor checks every consumed word
// against a queue of expected words pushed by the stimulus.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic       sin = 1'b1;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_valid, busy, frame_err, parity_err, overrun;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  serial_frame_rx #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a word is consumed on each edge where valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {28'd0, out_data}, 32'hdead);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("word", {28'd0, out_data}, {28'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame; gap idle cycles (bit_en=0) follow each strobed bit.
  task automatic send(input logic [3:0] d, input logic p, input logic stp,
                      input int gap, input logic rdy_stop);
    logic [6:0] b;
    b = {stp, p, d, 1'b0};
    for (int i = 0; i < 7; i++) begin
      sin       = b[i];
      bit_en    = 1'b1;
      out_ready = (i == 6) ? rdy_stop : 1'b0;
      tick();
      out_ready = 1'b0;
      if (gap > 0 && i < 6) begin
        bit_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
          tick();
          if (g == gap - 1) chk("busy_gap", busy, 1);
        end
      end
    end
    sin    = 1'b1;
    bit_en = 1'b1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
  endtask

  initial begin
    // reset then idle
    repeat (2) tick();
    rst = 1'b0;
    bit_en = 1'b1;
    repeat (10) tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_data", out_data, 0);
    chk("idle_errs", {frame_err, parity_err, overrun}, 0);

    // good frame 1101, parity 1
    exp_q.push_back(4'b1101);
    send(4'b1101, 1'b1, 1'b1, 0, 1'b0);
    chk("good_valid", out_valid, 1);
    chk("good_data", out_data, 4'b1101);
    chk("good_busy", busy, 0);
    chk("good_errs", {frame_err, parity_err, overrun}, 0);
    drain();

    // parity error
    send(4'b1101, 1'b0, 1'b1, 0, 1'b0);
    chk("perr_pulse", parity_err, 1);
    chk("perr_frame", frame_err, 0);
    chk("perr_valid", out_valid, 0);
    tick();
    chk("perr_one_cycle", parity_err, 0);

    // framing error: 0,0,0,1,0,1,0
    send(4'b0100, 1'b1, 1'b0, 0, 1'b0);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_parity", parity_err, 0);
    chk("ferr_valid", out_valid, 0);
    tick();
    chk("ferr_one_cycle", frame_err, 0);

    // overrun: second word dropped, held word kept
    exp_q.push_back(4'b1101);
    send(4'b1101, 1'b1, 1'b1, 0, 1'b0);
    send(4'b0011, 1'b0, 1'b1, 0, 1'b0);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_data", out_data, 4'b1101);
    tick();
    chk("ovr_one_cycle", overrun, 0);

    // accept and load on the same stop edge
    exp_q.push_back(4'b0011);
    send(4'b0011, 1'b0, 1'b1, 0, 1'b1);
    chk("b2b_overrun", overrun, 0);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, 4'b0011);
    drain();

    // bit_en only every 3rd cycle
    exp_q.push_back(4'b1101);
    send(4'b1101, 1'b1, 1'b1, 2, 1'b0);
    chk("thr_valid", out_valid, 1);
    chk("thr_data", out_data, 4'b1101);
    chk("thr_errs", {frame_err, parity_err, overrun}, 0);
    drain();

    // async reset after the 2nd data bit of 0110
    sin = 1'b0; tick();
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    tick();
    rst = 1'b0;
    sin = 1'b1;
    tick();
    exp_q.push_back(4'b0110);
    send(4'b0110, 1'b0, 1'b1, 0, 1'b0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 4'b0110);
    drain();

    repeat (2) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial frame receiver and deserializer. Consumes the 1-bit serial stream produced by the upstream universal shift register or a serial line driven from it.
- Each frame is: start bit, WIDTH data bits (LSB first), optional even-parity bit, stop bit.
- Delivers each good word on a valid/ready parallel port and reports framing, parity and overrun errors.
- Sits between the shift-register serial output and the parallel consumer logic.

Parameters:
- WIDTH, 4: data bits per frame; legal range 2..16.
- PARITY_EN, 1: 1 = frame carries an even-parity bit after the data; 0 = no parity bit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- bit_en  input  1  bit strobe; sin is sampled only on clk edges where bit_en=1.
- sin  input  1  serial data in; line idles at 1.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  received word; held stable while out_valid=1.
- out_valid  output  1  out_data holds an unconsumed word.
- busy  output  1  1 in any state other than IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- parity_err  output  1  one-cycle pulse: parity mismatch at stop.
- overrun  output  1  one-cycle pulse: good word lost because the holding register was full.

Behaviour:
- Reset (async, rst=1): state=IDLE, bit counter=0, shift reg=0, out_data=0, out_valid=0, busy=0, frame_err=0, parity_err=0, overrun=0. Reset mid-frame aborts the frame and discards partial data. Reset while out_valid=1 discards the held word.
- State changes happen only on edges with bit_en=1, except for output handshake updates, which happen every edge.
- IDLE: on sin=0, go to DATA and clear the counter. On sin=1, stay in IDLE.
- DATA: each bit is shifted in LSB first (new bit enters the MSB, the register shifts right) and the counter increments. After the WIDTH-th bit, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: latch perr = sin XOR (XOR-reduce of the shift reg), then go to STOP. With PARITY_EN=0, perr is 0.
- STOP: always return to IDLE. The stop edge handles the result as follows:
  - sin=0: pulse frame_err and drop the word. frame_err takes priority over parity_err; only one error pulses per frame.
  - sin=1 and perr=1: pulse parity_err and drop the word.
  - sin=1 and perr=0: the word is good.
    - If out_valid=0, or out_valid=1 with out_ready=1 on this edge: load out_data and set out_valid=1.
    - Otherwise: pulse overrun, drop the new word, and keep the held word unchanged.
- After a frame_err, the receiver goes straight to IDLE. A following 0 is treated as a new start bit.
- Latency: out_valid is high in the cycle after the stop-bit sampling edge.
- Handshake:
  - out_valid=1 and out_ready=1 with no simultaneous load: clear out_valid next cycle.
  - Accept and load on the same edge: out_valid stays 1 and out_data takes the new word.
- Error pulses are registered, high for exactly one cycle after the stop edge, and 0 otherwise.
- bit_en=0 for any number of cycles freezes state, counter and shift reg. The output handshake stays live during this time.
- The counter is sized $clog2(WIDTH+1) and never wraps past WIDTH.

Test Plan (WIDTH=4, PARITY_EN=1, bit_en=1 every cycle unless stated):
- Reset then idle: sin=1 held for 10 cycles -> busy=0, out_valid=0, all error flags 0.
- Good frame: sin = 0,1,0,1,1,1,1 (start; data 1,0,1,1; parity 1; stop) with out_ready=0 -> out_data=4'b1101 and out_valid=1 the cycle after the stop edge. Raising out_ready for 1 cycle then clears out_valid.
- Parity error: sin = 0,1,0,1,1,0,1 -> one-cycle parity_err pulse, out_valid stays 0. Framing error: sin = 0,0,0,1,0,1,0 -> one-cycle frame_err pulse, out_valid stays 0.
- Overrun and back-to-back: send 4'b1101 with out_ready=0, then send 4'b0011 -> overrun pulses and out_data remains 4'b1101. Repeat with out_ready=1 asserted on the second stop edge -> out_data=4'b0011, out_valid stays 1, no overrun.
- bit_en throttling: good frame with bit_en=1 only every 3rd cycle (sin changed only on strobe cycles) -> same result as the good-frame case, and busy stays high across the gaps.
- Async reset mid-frame: assert rst after the 2nd data bit -> outputs go to 0 immediately. A following full good frame 4'b0110 (parity 0) is received correctly.
